// File: rtl/button_debounce.sv
// button_debounce
// Turns one raw, bouncing push-button pin into clean single-clock events:
// a debounced level, one-cycle press/release/long-press pulses and a
// press-toggled LED drive bit.

module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = 250000,
    parameter int unsigned LONG_PRESS_CYCLES = 25000000,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long_press,
    output logic o_toggle
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    // Pin level seen while the button is not pressed.
    localparam logic RELEASED_PIN = ACTIVE_LOW;

    typedef enum logic [1:0] {
        Released,
        DebPress,
        Held,
        DebRelease
    } state_t;

    logic sync1_q;
    logic sync2_q;
    logic pressed;

    state_t            state_q,    state_d;
    logic [DEB_W-1:0]  debCnt_q,   debCnt_d;
    logic [HOLD_W-1:0] holdCnt_q,  holdCnt_d;
    logic              longDone_q, longDone_d;
    logic              level_q,    level_d;
    logic              press_q,    press_d;
    logic              release_q,  release_d;
    logic              long_q,     long_d;
    logic              toggle_q,   toggle_d;

    // Two-flop synchronizer; reset to the idle pin level so reset never looks like a press.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q <= RELEASED_PIN;
            sync2_q <= RELEASED_PIN;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
        end
    end

    // Normalise polarity so that 1 always means the button is pressed.
    assign pressed = sync2_q ^ ACTIVE_LOW;

    // State, counters and registered outputs; reset aborts any debounce or hold silently.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= Released;
            debCnt_q   <= '0;
            holdCnt_q  <= '0;
            longDone_q <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            toggle_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            debCnt_q   <= debCnt_d;
            holdCnt_q  <= holdCnt_d;
            longDone_q <= longDone_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            toggle_q   <= toggle_d;
        end
    end

    // Next-state logic: accept a level only after it is stable long enough; pulses default low.
    always_comb begin
        state_d    = state_q;
        debCnt_d   = debCnt_q;
        holdCnt_d  = holdCnt_q;
        longDone_d = longDone_q;
        level_d    = level_q;
        toggle_d   = toggle_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;

        case (state_q)
            Released: begin
                if (pressed) begin
                    state_d  = DebPress;
                    debCnt_d = '0;
                end
            end
            DebPress: begin
                if (!pressed) begin
                    state_d = Released;
                end else if (debCnt_q == DEB_LAST) begin
                    state_d    = Held;
                    level_d    = 1'b1;
                    press_d    = 1'b1;
                    toggle_d   = ~toggle_q;
                    holdCnt_d  = '0;
                    longDone_d = 1'b0;
                end else begin
                    debCnt_d = debCnt_q + DEB_ONE;
                end
            end
            Held: begin
                if (!pressed) begin
                    state_d  = DebRelease;
                    debCnt_d = '0;
                end else if ((holdCnt_q == HOLD_LAST) && !longDone_q) begin
                    long_d     = 1'b1;
                    longDone_d = 1'b1;
                end else if (holdCnt_q < HOLD_LAST) begin
                    holdCnt_d = holdCnt_q + HOLD_ONE;
                end
            end
            DebRelease: begin
                if (pressed) begin
                    state_d = Held;
                end else if (debCnt_q == DEB_LAST) begin
                    state_d   = Released;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    debCnt_d = debCnt_q + DEB_ONE;
                end
            end
            default: begin
                state_d = Released;
            end
        endcase
    end

    assign o_level      = level_q;
    assign o_press      = press_q;
    assign o_release    = release_q;
    assign o_long_press = long_q;
    assign o_toggle     = toggle_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
// Directed, table-driven bench for button_debounce with short debounce and
// long-press windows (4 and 16 cycles, active-low pin).

module tb_button_debounce;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 16;

    logic i_clk;
    logic i_rst_n;
    logic i_btn;
    logic o_level;
    logic o_press;
    logic o_release;
    logic o_long_press;
    logic o_toggle;

    int checks;
    int errors;

    // One table row: pin value driven before an edge and the outputs required after it.
    // Output order: {level, press, release, long_press, toggle}.
    typedef struct {
        logic       btn;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[8];

    button_debounce #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .ACTIVE_LOW       (1'b1)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_btn       (i_btn),
        .o_level     (o_level),
        .o_press     (o_press),
        .o_release   (o_release),
        .o_long_press(o_long_press),
        .o_toggle    (o_toggle)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Drive inputs, take one rising edge, then settle 1 unit away from the edge.
    task automatic applyStimulus(input logic rstN, input logic btn);
        i_rst_n = rstN;
        i_btn   = btn;
        @(posedge i_clk);
        #1;
    endtask

    // Compare all five outputs against the required vector.
    task automatic checkOutput(input string name, input logic [4:0] exp);
        logic [4:0] got;
        got = {o_level, o_press, o_release, o_long_press, o_toggle};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got lvl/prs/rel/lng/tgl=%b required %b", name, got, exp);
        end
    endtask

    // Full press from the released state; press is accepted on the 7th edge.
    task automatic pressAndCheck(input string name, input logic toggleAfter);
        for (int j = 0; j < DEB + 3; j++) begin
            applyStimulus(1'b1, 1'b0);
            if (j == DEB + 2)
                checkOutput(name, {1'b1, 1'b1, 1'b0, 1'b0, toggleAfter});
            else
                checkOutput(name, {1'b0, 1'b0, 1'b0, 1'b0, ~toggleAfter});
        end
    endtask

    // Full release from the held state; release is accepted on the 7th edge.
    task automatic releaseAndCheck(input string name, input logic toggleNow);
        for (int j = 0; j < DEB + 3; j++) begin
            applyStimulus(1'b1, 1'b1);
            if (j == DEB + 2)
                checkOutput(name, {1'b0, 1'b0, 1'b1, 1'b0, toggleNow});
            else
                checkOutput(name, {1'b1, 1'b0, 1'b0, 1'b0, toggleNow});
        end
    endtask

    // Main test sequence.
    initial begin
        checks  = 0;
        errors  = 0;
        i_rst_n = 1'b0;
        i_btn   = 1'b1;

        // Press acceptance: pin goes low at edge k, press lands at edge k+6.
        for (int i = 0; i < 6; i++) begin
            vecs[i].btn = 1'b0;
            vecs[i].exp = 5'b00000;
        end
        vecs[6].btn = 1'b0; vecs[6].exp = 5'b11001;
        vecs[7].btn = 1'b0; vecs[7].exp = 5'b10001;

        // Reset state.
        applyStimulus(1'b0, 1'b1);
        checkOutput("reset0", 5'b00000);
        applyStimulus(1'b0, 1'b1);
        checkOutput("reset1", 5'b00000);

        // Idle pin for 50 cycles: nothing happens.
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("idle", 5'b00000);
        end

        // Table-driven press acceptance.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].btn);
            checkOutput($sformatf("press_vec%0d", i), vecs[i].exp);
        end

        // Keep holding: long press exactly 16 edges after the press edge, only once.
        for (int i = 2; i <= 30; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("hold_p%0d", i), {1'b1, 1'b0, 1'b0, (i == LONG), 1'b1});
        end

        // Release: pulse 6 edges after the release edge.
        releaseAndCheck("release1", 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("after_release1", 5'b00001);

        // Bounce: 3 low / 2 high five times, then high; never accepted.
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 5; j++) begin
                applyStimulus(1'b1, (j < 3) ? 1'b0 : 1'b1);
                checkOutput($sformatf("bounce_r%0d_%0d", r, j), 5'b00001);
            end
        end
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("bounce_settle", 5'b00001);
        end

        // Press, then a 2-cycle high glitch while held; long press slips by 3 frozen edges.
        pressAndCheck("press2", 1'b0);
        for (int i = 1; i <= 25; i++) begin
            applyStimulus(1'b1, (i == 6 || i == 7) ? 1'b1 : 1'b0);
            checkOutput($sformatf("glitch_p%0d", i), {1'b1, 1'b0, 1'b0, (i == LONG + 3), 1'b0});
        end

        // Start a release, reset while still debouncing it: no release pulse ever.
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("deb_release", 5'b10000);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("mid_release_reset", 5'b00000);
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("post_reset_idle", 5'b00000);
        end

        // Two full presses after reset: toggle reads 1 then 0.
        pressAndCheck("press3", 1'b1);
        releaseAndCheck("release3", 1'b1);
        pressAndCheck("press4", 1'b0);
        releaseAndCheck("release4", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-side block for the board's status LED path: conditions one raw, asynchronous push-button pin into clean, single-clock-domain events.
- Outputs: debounced level, one-cycle press/release/long-press pulses, and a press-toggled LED drive bit.
- Sits between the board button pin and the LED blink logic.

Parameters:
DEBOUNCE_CYCLES, 250000, stable cycles required to accept a level change (10 ms at 25 MHz); legal range >= 2.
LONG_PRESS_CYCLES, 25000000, cycles in HELD before o_long_press fires (1 s at 25 MHz); legal range >= 2.
ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
i_clk  input  1  system clock.
i_rst_n  input  1  reset, synchronous to i_clk, active-low.
i_btn  input  1  raw button pin; asynchronous, may bounce.
o_level  output  1  debounced state; 1 = pressed.
o_press  output  1  one-cycle pulse on an accepted press.
o_release  output  1  one-cycle pulse on an accepted release.
o_long_press  output  1  one-cycle pulse, at most once per press.
o_toggle  output  1  flips on every o_press; drives LED.

Behaviour:
- Reset: synchronous, active-low (i_rst_n=0 sampled on the i_clk rising edge).
  - All outputs reset to 0.
  - State resets to RELEASED; all counters reset to 0.
  - Both synchronizer flops reset to the released pin value (ACTIVE_LOW ? 1 : 0).
  - Reset asserted mid-debounce or mid-hold aborts with no pulse emitted.
- Synchronizer: two flops, s1 <= i_btn, s2 <= s1.
  - p = s2 XOR ACTIVE_LOW, so p = 1 means pressed.
  - The FSM uses only p.
- Counters:
  - deb_cnt width = clog2(DEBOUNCE_CYCLES).
  - hold_cnt width = clog2(LONG_PRESS_CYCLES).
  - long_done: 1 bit.
- FSM transitions (evaluated at each rising edge):
  - RELEASED: p=1 -> DEB_PRESS, deb_cnt=0.
  - DEB_PRESS:
    - p=0 -> RELEASED. Glitch rejected, no pulse.
    - p=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> HELD: o_level=1, o_press=1, o_toggle inverted, hold_cnt=0, long_done=0.
    - Otherwise deb_cnt++.
  - HELD:
    - p=0 -> DEB_RELEASE, deb_cnt=0.
    - Else if hold_cnt==LONG_PRESS_CYCLES-1 and long_done=0 -> o_long_press=1, long_done=1.
    - Else if hold_cnt<LONG_PRESS_CYCLES-1 -> hold_cnt++ (saturates).
  - DEB_RELEASE:
    - p=1 -> HELD. No pulse; hold_cnt and long_done preserved, not restarted.
    - p=0 and deb_cnt==DEBOUNCE_CYCLES-1 -> RELEASED: o_level=0, o_release=1.
    - Otherwise deb_cnt++.
    - hold_cnt frozen while in this state.
- Pulse outputs:
  - o_press, o_release and o_long_press are registered and high for exactly one cycle.
  - They default to 0 every cycle not named above.
- Latency:
  - Let k be the first edge at which s1 captures the new pin value.
  - o_level/o_press update at edge k+DEBOUNCE_CYCLES+2.
  - Release path has the same latency.
  - o_long_press fires LONG_PRESS_CYCLES edges after the o_press edge, if the button stays in HELD throughout.
- Glitch rule: any level held for fewer than DEBOUNCE_CYCLES+1 consecutive synchronized samples produces no output change.
- Simultaneous events:
  - In HELD, when p=0 on the same edge that long-press would fire, the transition to DEB_RELEASE takes priority and no long pulse is emitted that cycle.
  - The long pulse can still fire after a bounce returns the FSM to HELD.
- Exclusivity: o_press and o_release are never high together. o_level changes only on edges that emit o_press or o_release.

Test Plan:
(bench parameters: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, ACTIVE_LOW=1)
1. Reset with i_btn=1, then hold i_btn=1 for 50 cycles -> all outputs stay 0, no pulses.
2. Drive i_btn 1->0 at edge k and hold -> o_level rises and o_press pulses exactly at edge k+6; o_toggle goes 0->1.
3. Bounce i_btn low for 3 cycles, high for 2, repeated 5 times, then high -> zero pulses; o_level stays 0.
4. Hold press for 30 cycles after o_press -> one o_long_press pulse, 16 edges after o_press; no second pulse. Then release -> o_release pulse 6 edges after the release edge.
5. While in HELD, inject a 2-cycle high glitch, then continue holding -> o_level stays 1, no o_release. Long-press timing is extended by the glitch's frozen cycles.
6. Press accepted, then assert i_rst_n=0 for 1 cycle mid-DEB_RELEASE -> all outputs 0 on the next edge, no o_release. Two further full presses -> o_toggle reads 1 then 0.
